rotating_square_monitor: RTL and testbench

Passive observer on the multiplexed seven-segment bus (active-low CA/AN) produced by the rotating-square display driver. It reconstructs the per-digit segment images from the time-multiplexed scan, locates the square, and reports its position and the rotation step each frame. The block sits beside the display driver in simulation and on-board self-check builds, with no back-pressure into the display path.

---
 rtl/rotating_square_monitor_pkg.sv | 45 ++++
 rtl/rotating_square_monitor_if.sv | 12 +
 rtl/rotating_square_monitor_seg_scan_capture.sv | 83 ++++++++
 rtl/rotating_square_monitor.sv | 137 +++++++++++++
 tb/tb_rotating_square_monitor.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rotating_square_monitor_pkg.sv
// Shared types and constants for the seven-segment rotating-square monitor.
// Latency: none (types, constants and a pure decode function only).
// Backpressure: not applicable.
package rotating_square_monitor_pkg;

  typedef logic [6:0] seg_t;

  // Active-low images, bit 0 = segment a ... bit 6 = segment g
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_SQ_UP = 7'b0011100;  // a,b,f,g lit
  localparam seg_t SEG_SQ_LO = 7'b0100011;  // c,d,e,g lit

  // Active-low images of hex digits 0..F
  localparam seg_t HEX_IMG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [2:0] {
    STEP_NONE,
    STEP_CW,
    STEP_CCW,
    STEP_STALL,
    STEP_ERR
  } step_e;

  typedef struct packed {
    logic       ok;
    logic [3:0] val;
  } hex_t;

  // Map an active-low image to its hex value; ok=0, val=0 when not a hex glyph
  function automatic hex_t seg_to_hex(seg_t s);
    hex_t h;
    h = '0;
    for (int i = 0; i < 16; i++) begin
      if (s == HEX_IMG[i]) begin
        h.ok  = 1'b1;
        h.val = 4'(i);
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/rotating_square_monitor_if.sv
// Multiplexed seven-segment bus (active-low CA segments, active-low AN digit enables).
// Latency: none (wires only).
// Backpressure: none; the display driver is the master, monitors only listen.
interface rotating_square_monitor_if #(
  parameter int NUM_DIGITS = 8
);
  logic [6:0]            CA;
  logic [NUM_DIGITS-1:0] AN;

  modport master (output CA, output AN);
  modport slave  (input  CA, input  AN);
endinterface

// File: rtl/rotating_square_monitor_seg_scan_capture.sv
// Rebuilds per-digit images from the scanned bus and flags each completed frame.
// Latency: pin change -> image write 1+STABLE_CYC cycles; last write -> frame_done +1.
// Backpressure: none; purely observes the bus.
module seg_scan_capture
  import rotating_square_monitor_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  seg_t                      ca,
  input  logic [NUM_DIGITS-1:0]     an,
  output logic [7*NUM_DIGITS-1:0]   seg_img,
  output logic                      frame_done
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYC);

  seg_t                    r_ca_q,   r_ca_d;
  logic [NUM_DIGITS-1:0]   r_an_q,   r_an_d;
  logic [NUM_DIGITS+6:0]   prev_q,   prev_d;
  logic [7:0]              cnt_q,    cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q,   seen_d;
  logic [7*NUM_DIGITS-1:0] img_q,    img_d;
  logic                    fdone_q,  fdone_d;
  logic                    one_hot;
  logic                    same;
  logic                    capture;

  // Dwell tracking, image write on the cycle the count first reaches STABLE, frame bookkeeping
  always_comb begin
    r_ca_d  = ca;
    r_an_d  = an;
    prev_d  = {r_an_q, r_ca_q};
    one_hot = $onehot(~r_an_q);
    same    = ({r_an_q, r_ca_q} == prev_q);
    cnt_d   = cnt_q;
    if (!one_hot) begin
      cnt_d = 8'd0;
    end else if (same) begin
      if (cnt_q != STABLE) cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = 8'd1;
    end
    // A fresh dwell that reloads straight to STABLE (STABLE_CYC=1) must still capture
    capture = one_hot && (cnt_d == STABLE) && (!same || (cnt_q != STABLE));
    fdone_d = &seen_q;
    seen_d  = (&seen_q) ? '0 : seen_q;
    img_d   = img_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (capture && !r_an_q[d]) begin
        img_d[7*d +: 7] = r_ca_q;
        seen_d[d]       = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ca_q  <= SEG_BLANK;
      r_an_q  <= '1;
      prev_q  <= '1;
      cnt_q   <= 8'd0;
      seen_q  <= '0;
      img_q   <= {NUM_DIGITS{SEG_BLANK}};
      fdone_q <= 1'b0;
    end else begin
      r_ca_q  <= r_ca_d;
      r_an_q  <= r_an_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      img_q   <= img_d;
      fdone_q <= fdone_d;
    end
  end

  assign seg_img    = img_q;
  assign frame_done = fdone_q;

endmodule

// File: rtl/rotating_square_monitor.sv
// Locates the rotating square in each captured frame and reports position and step direction.
// Latency: frame_done -> sq_valid/pos/step pulses +1 cycle. Optional hex decode: SEVENSEG_MONITOR_HEX_EN.
// Backpressure: none; passive observer, results are single-cycle pulses.
module rotating_square_monitor
  import rotating_square_monitor_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CYC = 4,
  localparam int PW        = $clog2(2*NUM_DIGITS)
) (
  input  logic                     clk,
  input  logic                     rst,
  rotating_square_monitor_if.slave bus,
  output logic [7*NUM_DIGITS-1:0]  seg_img,
  output logic                     frame_done,
  output logic                     sq_valid,
  output logic [PW-1:0]            pos,
  output logic                     step_cw,
  output logic                     step_ccw,
  output logic                     stall,
  output logic                     err,
  output logic [4*NUM_DIGITS-1:0]  hex_val,
  output logic [NUM_DIGITS-1:0]    hex_ok
);

  localparam logic [PW:0] MOD = (PW+1)'(2*NUM_DIGITS);

  seg_scan_capture #(
    .NUM_DIGITS (NUM_DIGITS),
    .STABLE_CYC (STABLE_CYC)
  ) u_capture (
    .clk        (clk),
    .rst        (rst),
    .ca         (bus.CA),
    .an         (bus.AN),
    .seg_img    (seg_img),
    .frame_done (frame_done)
  );

  logic          sq_valid_q, sq_valid_d;
  logic [PW-1:0] pos_q,      pos_d;
  logic          prev_vld_q, prev_vld_d;
  step_e         step_q,     step_d;
  logic [PW-1:0] pos_new;
  logic          found, multi, other, frame_ok;
  logic [PW:0]   diff;
  logic [PW-1:0] delta;
  seg_t          img;

  // Classify the frame image and work out the step relative to the last valid position
  always_comb begin
    pos_new = '0;
    found   = 1'b0;
    multi   = 1'b0;
    other   = 1'b0;
    img     = SEG_BLANK;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      img = seg_img[7*d +: 7];
      if (img == SEG_SQ_UP || img == SEG_SQ_LO) begin
        if (found) multi = 1'b1;
        found   = 1'b1;
        pos_new = (img == SEG_SQ_UP) ? PW'(d) : PW'(2*NUM_DIGITS-1-d);
      end else if (img != SEG_BLANK) begin
        other = 1'b1;
      end
    end
    frame_ok = found && !multi && !other;

    diff = {1'b0, pos_new} + MOD - {1'b0, pos_q};
    if (diff >= MOD) diff = diff - MOD;
    delta = diff[PW-1:0];

    sq_valid_d = sq_valid_q;
    pos_d      = pos_q;
    prev_vld_d = prev_vld_q;
    step_d     = STEP_NONE;
    if (frame_done) begin
      if (frame_ok) begin
        sq_valid_d = 1'b1;
        pos_d      = pos_new;
        prev_vld_d = 1'b1;
        if (prev_vld_q) begin
          if (delta == PW'(1))                    step_d = STEP_CW;
          else if (delta == PW'(2*NUM_DIGITS-1))  step_d = STEP_CCW;
          else if (delta == '0)                   step_d = STEP_STALL;
          else                                    step_d = STEP_ERR;
        end
      end else begin
        sq_valid_d = 1'b0;
        prev_vld_d = 1'b0;
        step_d     = STEP_ERR;
      end
    end
  end

  // Result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_valid_q <= 1'b0;
      pos_q      <= '0;
      prev_vld_q <= 1'b0;
      step_q     <= STEP_NONE;
    end else begin
      sq_valid_q <= sq_valid_d;
      pos_q      <= pos_d;
      prev_vld_q <= prev_vld_d;
      step_q     <= step_d;
    end
  end

  assign sq_valid = sq_valid_q;
  assign pos      = pos_q;
  assign step_cw  = (step_q == STEP_CW);
  assign step_ccw = (step_q == STEP_CCW);
  assign stall    = (step_q == STEP_STALL);
  assign err      = (step_q == STEP_ERR);

`ifdef SEVENSEG_MONITOR_HEX_EN
  hex_t hx;

  // Decode every captured image to hex alongside seg_img
  always_comb begin
    hex_val = '0;
    hex_ok  = '0;
    hx      = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      hx              = seg_to_hex(seg_img[7*d +: 7]);
      hex_val[4*d +: 4] = hx.val;
      hex_ok[d]       = hx.ok;
    end
  end
`else
  assign hex_val = '0;
  assign hex_ok  = '0;
`endif

endmodule

// File: tb/tb_rotating_square_monitor.sv
module tb_rotating_square_monitor;
  import rotating_square_monitor_pkg::*;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7*N-1:0] seg_img;
  logic          frame_done, sq_valid, step_cw, step_ccw, stall, err;
  logic [3:0]    pos;
  logic [4*N-1:0] hex_val;
  logic [N-1:0]  hex_ok;

  rotating_square_monitor_if #(.NUM_DIGITS(N)) bus ();

  rotating_square_monitor #(.NUM_DIGITS(N), .STABLE_CYC(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .seg_img    (seg_img),
    .frame_done (frame_done),
    .sq_valid   (sq_valid),
    .pos        (pos),
    .step_cw    (step_cw),
    .step_ccw   (step_ccw),
    .stall      (stall),
    .err        (err),
    .hex_val    (hex_val),
    .hex_ok     (hex_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int res_cnt = 0;
  int fd_cnt = 0;
  int stray = 0;
  int nframes = 0;
  logic fd_prev = 1'b0;
  logic res_valid;
  logic [3:0] res_pos;
  logic [3:0] res_pulses;

  // Record the result cycle following each frame_done; any other pulse is stray
  always @(negedge clk) begin
    if (rst) begin
      fd_prev = 1'b0;
    end else begin
      if (fd_prev) begin
        res_valid  = sq_valid;
        res_pos    = pos;
        res_pulses = {step_cw, step_ccw, stall, err};
        res_cnt++;
      end else if ({step_cw, step_ccw, stall, err} != 4'b0) begin
        stray++;
      end
      if (frame_done) fd_cnt++;
      fd_prev = frame_done;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7*N-1:0] one_sq(input int d, input seg_t s);
    logic [7*N-1:0] f;
    f = {N{SEG_BLANK}};
    f[7*d +: 7] = s;
    return f;
  endfunction

  task automatic idle(input int n);
    bus.AN = '1;
    bus.CA = SEG_BLANK;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input logic [7*N-1:0] img, input int dwell, input int ndig);
    for (int d = 0; d < ndig; d++) begin
      bus.AN = ~(N'(1) << d);
      bus.CA = img[7*d +: 7];
      repeat (dwell) begin
        @(posedge clk);
        #1;
      end
    end
    bus.AN = '1;
    bus.CA = SEG_BLANK;
  endtask

  // pulses are {step_cw, step_ccw, stall, err}
  task automatic do_frame(input string tag, input logic [7*N-1:0] img,
                          input logic ev, input logic [3:0] ep, input logic [3:0] epl);
    int n;
    nframes++;
    scan(img, 6, N);
    n = 0;
    while (res_cnt != nframes && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_result_seen"}, 64'(res_cnt), 64'(nframes));
    chk({tag, "_sq_valid"},    64'(res_valid), 64'(ev));
    chk({tag, "_pos"},         64'(res_pos), 64'(ep));
    chk({tag, "_pulses"},      64'(res_pulses), 64'(epl));
    idle(3);
  endtask

  initial begin
    int fd0;
    logic [7*N-1:0] f;
    rst = 1'b1;
    bus.AN = '1;
    bus.CA = SEG_BLANK;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_seg_img",    64'(seg_img), 64'({N{7'h7F}}));
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_sq_valid",   64'(sq_valid), 64'd0);
    chk("rst_pos",        64'(pos), 64'd0);
    chk("rst_pulses",     64'({step_cw, step_ccw, stall, err}), 64'd0);

    do_frame("first_up2", one_sq(2, SEG_SQ_UP), 1'b1, 4'd2, 4'b0000);
    chk("img_up2", 64'(seg_img), 64'(one_sq(2, SEG_SQ_UP)));
    do_frame("cw_up3",   one_sq(3, SEG_SQ_UP), 1'b1, 4'd3, 4'b1000);
    do_frame("ccw_up2",  one_sq(2, SEG_SQ_UP), 1'b1, 4'd2, 4'b0100);
    do_frame("jump_up7", one_sq(7, SEG_SQ_UP), 1'b1, 4'd7, 4'b0001);
    do_frame("wrap_lo7", one_sq(7, SEG_SQ_LO), 1'b1, 4'd8, 4'b1000);
    do_frame("jump_lo0", one_sq(0, SEG_SQ_LO), 1'b1, 4'd15, 4'b0001);
    do_frame("wrap_up0", one_sq(0, SEG_SQ_UP), 1'b1, 4'd0, 4'b1000);

    f = one_sq(0, SEG_SQ_UP);
    f[7*5 +: 7] = SEG_SQ_LO;
    do_frame("two_sq",     f,                    1'b0, 4'd0, 4'b0001);
    do_frame("after_inv",  one_sq(4, SEG_SQ_UP), 1'b1, 4'd4, 4'b0000);
    do_frame("stall_up4",  one_sq(4, SEG_SQ_UP), 1'b1, 4'd4, 4'b0010);

    // Dwell one cycle short of the stability threshold: nothing captured
    fd0 = fd_cnt;
    scan(one_sq(1, SEG_SQ_UP), 3, N);
    idle(20);
    chk("short_dwell_no_fd", 64'(fd_cnt), 64'(fd0));
    chk("short_dwell_img",   64'(seg_img), 64'(one_sq(4, SEG_SQ_UP)));

    // Two digit enables low at once: never accepted
    bus.AN = 8'hFC;
    bus.CA = SEG_SQ_LO;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    idle(5);
    chk("multi_an_no_fd", 64'(fd_cnt), 64'(fd0));
    chk("multi_an_img",   64'(seg_img), 64'(one_sq(4, SEG_SQ_UP)));

    do_frame("stall_again", one_sq(4, SEG_SQ_UP), 1'b1, 4'd4, 4'b0010);

    // Reset in the middle of a frame discards the partial image and the previous position
    scan(one_sq(1, SEG_SQ_UP), 6, 4);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_img",      64'(seg_img), 64'({N{7'h7F}}));
    chk("midrst_sq_valid", 64'(sq_valid), 64'd0);
    chk("midrst_pos",      64'(pos), 64'd0);
    do_frame("post_rst_up5", one_sq(5, SEG_SQ_UP), 1'b1, 4'd5, 4'b0000);

    // A hex glyph on digit 0 is not a square: invalid frame
    do_frame("hex_frame", one_sq(0, 7'b1000000), 1'b0, 4'd5, 4'b0001);
`ifdef SEVENSEG_MONITOR_HEX_EN
    chk("hex_val0", 64'(hex_val[3:0]), 64'd0);
    chk("hex_ok0",  64'(hex_ok[0]), 64'd1);
    chk("hex_ok1",  64'(hex_ok[1]), 64'd0);
    do_frame("hex_sq", one_sq(0, SEG_SQ_UP), 1'b1, 4'd0, 4'b0000);
    chk("hex_ok_sq", 64'(hex_ok[0]), 64'd0);
`else
    chk("hex_val_off", 64'(hex_val), 64'd0);
    chk("hex_ok_off",  64'(hex_ok), 64'd0);
`endif

    chk("no_stray_pulses", 64'(stray), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
